// File: rtl/pipe_sequencer.sv
// Pipeline sequencer: memory-wait freeze, redirect flush and load-use stall control,
// plus registered data-memory request, sticky timeout flag and saturating event counters.
module pipe_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_memread,
  input  logic        ex_redirect,
  input  logic        mem_access,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        pipe_freeze,
  output logic        dmem_req,
  output logic        mem_err,
  output logic [15:0] stall_cycles,
  output logic [7:0]  flush_count
);

  localparam logic ST_RUN     = 1'b0;
  localparam logic ST_MEMWAIT = 1'b1;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic        state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        dmem_req_q, dmem_req_d;
  logic        err_q, err_d;
  logic [15:0] stall_q, stall_d;
  logic [7:0]  flush_q, flush_d;

  logic freeze;
  logic load_use;
  logic redirect_taken;

  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  // Next state: the release cycle (ready or timeout) leaves the pipe unfrozen.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    freeze  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_access) begin
          freeze  = 1'b1;
          state_d = ST_MEMWAIT;
          wait_d  = '0;
        end
      end
      ST_MEMWAIT: begin
        if (dmem_ready) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else if (wait_q == TIMEOUT_C) begin
          err_d   = 1'b1;
          state_d = ST_RUN;
          wait_d  = '0;
        end else begin
          freeze  = 1'b1;
          wait_d  = wait_q + 8'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
    dmem_req_d = (state_d == ST_MEMWAIT);
  end

  always_comb begin
    pc_write       = 1'b0;
    ifid_write     = 1'b0;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    pipe_freeze    = 1'b0;
    redirect_taken = 1'b0;
    if (rst) begin
      pc_write = 1'b0;
    end else if (freeze) begin
      pipe_freeze = 1'b1;
    end else if (ex_redirect) begin
      redirect_taken = 1'b1;
      pc_write       = 1'b1;
      ifid_write     = 1'b1;
      ifid_flush     = 1'b1;
      idex_flush     = 1'b1;
    end else if (load_use) begin
      idex_flush = 1'b1;
    end else begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_write && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    if (redirect_taken && (flush_q != 8'hFF)) flush_d = flush_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_q     <= '0;
      dmem_req_q <= 1'b0;
      err_q      <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      dmem_req_q <= dmem_req_d;
      err_q      <= err_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign dmem_req     = dmem_req_q;
  assign mem_err      = err_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer: cycle-by-cycle comparison against a behavioural
// model of the freeze/redirect/load-use rules, plus literal pins on key counters.
module tb_pipe_sequencer;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_memread, ex_redirect, mem_access, dmem_ready;
  logic        pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze;
  logic        dmem_req, mem_err;
  logic [15:0] stall_cycles;
  logic [7:0]  flush_count;

  always #5 clk = ~clk;

  pipe_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_redirect(ex_redirect),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .pipe_freeze(pipe_freeze), .dmem_req(dmem_req), .mem_err(mem_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  int checks = 0;
  int errors = 0;

  // Model: "busy" means a memory access is outstanding; waited counts frozen wait cycles.
  bit m_busy;
  int m_waited;
  bit m_err;
  int m_stall;
  int m_flush;

  int req_hi, frz_hi;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0;
  endtask

  // Inputs are applied 1ns after a rising edge; outputs are compared at the falling edge.
  task automatic cycle();
    bit frozen, hit, e_pc, e_ifw, e_iff, e_idf, e_frz, e_err_next;
    #4;
    if (rst) model_reset();
    frozen = 0; e_err_next = m_err;
    if (!m_busy) frozen = mem_access;
    else if (dmem_ready) frozen = 0;
    else if (m_waited == int'(TO)) begin frozen = 0; e_err_next = 1; end
    else frozen = 1;
    hit = ex_memread && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
    e_pc = 0; e_ifw = 0; e_iff = 0; e_idf = 0; e_frz = 0;
    if (rst) ;
    else if (frozen) e_frz = 1;
    else if (ex_redirect) begin e_pc = 1; e_ifw = 1; e_iff = 1; e_idf = 1; end
    else if (hit) e_idf = 1;
    else begin e_pc = 1; e_ifw = 1; end

    chk("pc_write", pc_write, e_pc);
    chk("ifid_write", ifid_write, e_ifw);
    chk("ifid_flush", ifid_flush, e_iff);
    chk("idex_flush", idex_flush, e_idf);
    chk("pipe_freeze", pipe_freeze, e_frz);
    chk("dmem_req", dmem_req, m_busy);
    chk("mem_err", mem_err, m_err);
    chk("stall_cycles", stall_cycles, m_stall);
    chk("flush_count", flush_count, m_flush);
    if (dmem_req === 1'b1) req_hi++;
    if (pipe_freeze === 1'b1) frz_hi++;

    if (!rst) begin
      m_waited = (m_busy && frozen) ? m_waited + 1 : 0;
      m_busy   = frozen;
      m_err    = e_err_next;
      if (!e_pc) m_stall = (m_stall + 1 > 65535) ? 65535 : m_stall + 1;
      if (!frozen && ex_redirect) m_flush = (m_flush + 1 > 255) ? 255 : m_flush + 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    ex_memread = 0; ex_redirect = 0; mem_access = 0; dmem_ready = 0;
  endtask

  initial begin
    model_reset();
    rst = 1; idle();
    @(posedge clk); #1;
    // Reset with active inputs: every control output must stay low.
    mem_access = 1; ex_redirect = 1; ex_memread = 1; ex_rd = 3; id_rs1 = 3;
    cycle(); cycle();
    chk("reset_pc_write", pc_write, 0);
    rst = 0; idle();
    cycle(); cycle();

    // Load x5 in EX, ID reads x5 as rs2: one bubble.
    ex_memread = 1; ex_rd = 5; id_rs2 = 5; id_rs1 = 9;
    cycle();
    idle(); cycle();
    chk("lu_stall_count", stall_cycles, 1);

    // Redirect with simultaneous load-use on x7: redirect wins.
    ex_redirect = 1; ex_memread = 1; ex_rd = 7; id_rs1 = 7;
    cycle();
    idle(); cycle();
    chk("redir_flush_count", flush_count, 1);
    chk("redir_stall_count", stall_cycles, 1);

    // Memory access, ready after 3 wait cycles.
    req_hi = 0; frz_hi = 0;
    mem_access = 1;
    cycle(); cycle(); cycle(); cycle();
    dmem_ready = 1; cycle();
    chk("mem_req_cycles", req_hi, 4);
    chk("mem_freeze_cycles", frz_hi, 4);
    idle(); cycle();
    chk("mem_stall_count", stall_cycles, 5);
    chk("mem_req_after", dmem_req, 0);

    // Load-use through rs1, and non-load producer (no stall).
    ex_memread = 1; ex_rd = 12; id_rs1 = 12; id_rs2 = 1; cycle();
    ex_memread = 0; cycle();
    idle(); cycle();

    // Timeout: ready never comes.
    mem_access = 1;
    for (int unsigned i = 0; i < TO + 2; i++) cycle();
    idle(); cycle();
    chk("timeout_err", mem_err, 1);
    chk("timeout_req", dmem_req, 0);
    // Further traffic: error remains sticky.
    mem_access = 1; cycle(); dmem_ready = 1; cycle();
    idle(); ex_redirect = 1; cycle(); cycle();
    idle(); cycle();
    chk("err_sticky", mem_err, 1);

    // Reset mid-MEMWAIT.
    mem_access = 1; cycle(); cycle();
    rst = 1; #1;
    chk("rst_req_async", dmem_req, 0);
    chk("rst_err_async", mem_err, 0);
    chk("rst_stall_async", stall_cycles, 0);
    #1 cycle();
    rst = 0; idle(); cycle();
    chk("post_rst_freeze", pipe_freeze, 0);

    // 300 redirects saturate the flush counter.
    ex_redirect = 1;
    for (int unsigned i = 0; i < 300; i++) cycle();
    idle(); cycle();
    chk("flush_saturate", flush_count, 255);

    // x0 loads never stall.
    ex_memread = 1; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    for (int unsigned i = 0; i < 5; i++) cycle();
    idle(); cycle();
    chk("x0_no_stall", stall_cycles, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_sequencer.md
PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max MEMWAIT cycles before abort (1..255).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port id_rs1  input  5  source register 1 of instruction in ID.
REQ-005 SHALL have port id_rs2  input  5  source register 2 of instruction in ID.
REQ-006 SHALL have port ex_rd  input  5  destination register of instruction in EX.
REQ-007 SHALL have port ex_memread  input  1  EX instruction is a load.
REQ-008 SHALL have port ex_redirect  input  1  EX instruction is a taken branch, JAL or JALR.
REQ-009 SHALL have port mem_access  input  1  MEM-stage instruction is a load or store.
REQ-010 SHALL have port dmem_ready  input  1  data memory completes current access this cycle.
REQ-011 SHALL have port pc_write  output  1  PC register enable.
REQ-012 SHALL have port ifid_write  output  1  IF/ID register enable.
REQ-013 SHALL have port ifid_flush  output  1  IF/ID load-bubble.
REQ-014 SHALL have port idex_flush  output  1  ID/EX load-bubble.
REQ-015 SHALL have port pipe_freeze  output  1  hold ID/EX, EX/MEM, MEM/WB registers.
REQ-016 SHALL have port dmem_req  output  1  data memory request, registered.
REQ-017 SHALL have port mem_err  output  1  sticky timeout flag.
REQ-018 SHALL have port stall_cycles  output  16  saturating count of cycles with pc_write=0.
REQ-019 SHALL have port flush_count  output  8  saturating count of redirects honoured.

Function
REQ-020 SHALL implement FSM states RUN, MEMWAIT; reset state RUN.
REQ-021 RUN, mem_access=1: pipe_freeze=1, pc_write=0, ifid_write=0, flushes 0; next state MEMWAIT; dmem_req=1 from next cycle.
REQ-022 MEMWAIT, dmem_ready=0: same freeze outputs; 8-bit wait counter increments; dmem_req held 1.
REQ-023 MEMWAIT, dmem_ready=1 ("release cycle"): pipe_freeze=0, hazard logic (REQ-025..027) evaluated as in RUN; next state RUN; dmem_req=0 next cycle; wait counter cleared.
REQ-024 MEMWAIT, wait counter == TIMEOUT and dmem_ready=0: mem_err set (sticky until reset); release cycle as REQ-023; dmem_ready=1 on the same cycle takes precedence (no error).
REQ-025 Unfrozen cycle, ex_redirect=1: ifid_flush=1, idex_flush=1, pc_write=1, ifid_write=1; flush_count +1 (saturate at 255).
REQ-026 Unfrozen cycle, ex_redirect=0, load-use (ex_memread=1, ex_rd!=0, ex_rd==id_rs1 or ex_rd==id_rs2): pc_write=0, ifid_write=0, idex_flush=1, ifid_flush=0.
REQ-027 Unfrozen cycle, no redirect, no load-use: pc_write=1, ifid_write=1, all flushes 0.
REQ-028 Priority: memory freeze > redirect > load-use; redirect and load-use in same cycle -> redirect only (load-use bubble superseded by flush).
REQ-029 ex_rd=0 SHALL never cause a load-use stall.
REQ-030 stall_cycles SHALL increment every cycle pc_write=0 (rst low), saturating at 65535.
REQ-031 Hazard/flush outputs SHALL be combinational from state and inputs; dmem_req, mem_err, counters registered.

Reset
REQ-032 rst=1 SHALL immediately force state RUN, dmem_req=0, mem_err=0, wait counter 0, stall_cycles 0, flush_count 0.
REQ-033 While rst=1 SHALL drive pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=0, pipe_freeze=0, regardless of inputs.
REQ-034 rst asserted in MEMWAIT SHALL abort the access (dmem_req drops asynchronously), no mem_err.

Verification
REQ-035 Load x5 in EX, id_rs2=5, no other events -> one cycle pc_write=0, ifid_write=0, idex_flush=1; stall_cycles 0->1.
REQ-036 ex_redirect=1 with simultaneous load-use on x7 -> ifid_flush=1, idex_flush=1, pc_write=1; flush_count 0->1; stall_cycles unchanged.
REQ-037 mem_access=1, dmem_ready rises after 3 MEMWAIT cycles -> dmem_req high 4 cycles, pipe_freeze high 4 cycles (RUN entry + 3), release on 5th; stall_cycles +4.
REQ-038 TIMEOUT=4, dmem_ready held 0 -> mem_err=1 after 4 MEMWAIT cycles, state RUN, mem_err stays 1 through further traffic until rst.
REQ-039 rst pulsed mid-MEMWAIT -> dmem_req=0 same cycle, counters 0, state RUN, mem_err=0.
REQ-040 Drive 300 redirects -> flush_count saturates at 255; ex_rd=0 loads with id_rs1=0 -> no stalls.
